uart_rx: RTL

//  Serial-to-parallel receiver for 8N1 UART frames (1 start, 8 data LSB-first, 1 stop).

---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 131 +++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte bundle from the UART receiver to its consumer.
// Master drives the byte, its strobes and the busy flag; slave observes.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
        input rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, two-flop input sync, mid-bit sampling.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int CPB  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam logic [15:0] LAST = 16'(CPB - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [15:0] DP = 16'(HALF + 1);
    localparam logic [15:0] V0 = 16'(HALF - 1);
    localparam logic [15:0] V1 = 16'(HALF);
`else
    localparam logic [15:0] DP = 16'(HALF);
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rx_s1;
    logic        rx_s2;
    logic [15:0] clk_count;
    logic [3:0]  bit_idx;
    logic [7:0]  shift;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        ferr_q;
    logic        busy;
    logic        shift_en;
    logic        take;
    logic        drop;
    logic        sample;
    logic        dp;
    logic        last;

    assign dp   = (clk_count == DP);
    assign last = (clk_count == LAST);

`ifdef UART_RX_MAJORITY_EN
    logic v0;
    logic v1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b1;
            v1 <= 1'b1;
        end else begin
            if (clk_count == V0) v0 <= rx_s2;
            if (clk_count == V1) v1 <= rx_s2;
        end
    end

    // third vote is the live sample at the decision point
    assign sample = (v0 & v1) | (v0 & rx_s2) | (v1 & rx_s2);
`else
    assign sample = rx_s2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (!rx_s2) state_nxt = START;
            START: begin
                if (dp && sample) state_nxt = IDLE;
                else if (last)    state_nxt = DATA;
            end
            DATA:  if (last && bit_idx == 4'd8) state_nxt = STOP;
            STOP:  if (dp) state_nxt = sample ? IDLE : BREAK;
            BREAK: if (rx_s2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        shift_en = (state == DATA) && dp;
        take     = (state == STOP) && dp && sample;
        drop     = (state == STOP) && dp && !sample;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            clk_count <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            valid_q <= take;
            ferr_q  <= drop;
            if (take) data_q <= shift;
            // every state change restarts the bit period
            if (state_nxt != state || last ||
                state == IDLE || state == BREAK)
                clk_count <= '0;
            else
                clk_count <= clk_count + 16'd1;
            if (state != DATA) bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 4'd1;
            if (shift_en) shift <= {sample, shift[7:1]};
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = busy;
endmodule
